instruction_fetch_unit: RTL and testbench

//  Fetch stage upstream of instruction_memory: owns the PC, drives read_address, consumes the 32-bit instruction.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, FSM state encoding and the buffered fetch entry type
// used by the fetch stage and its fetch FIFO.
package fetch_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t BOOT = 1'b0;
  localparam fetch_state_t RUN  = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular queue of {pc, instr} entries between instruction memory and
// decode; synchronous flush discards everything buffered.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               entry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count < FULL) || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= entry;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues instruction-memory reads with credit-based
// flow control and hands {pc, instr} to decode. FETCH_PERF_EN builds the perf counters.
module instruction_fetch_unit #(
  parameter int              XLEN       = 64,
  parameter int              INSTR_W    = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_rd_en,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pc,
  output logic               fetch_misalign,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_redirects
);

  import fetch_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_t     state;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  inflight_pc;
  logic             inflight;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             fifo_empty;
  logic             req;
  logic             push;
  logic             handshake;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // Credit rule: a request is only issued if its response is guaranteed a slot.
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);
  assign id_valid  = !fifo_empty;
  assign handshake = id_valid && id_ready && !redirect_valid;
  assign req       = (state == RUN) && !redirect_valid &&
                     ((occupancy < DEPTH_C) || (id_valid && id_ready));
  assign push      = inflight && !redirect_valid;

  assign push_entry = '{pc: inflight_pc, instr: imem_instr};

  assign imem_rd_en = req;
  assign imem_addr  = req ? pc : '0;
  assign id_instr   = id_valid ? head.instr : '0;
  assign id_pc      = id_valid ? head.pc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      fetch_misalign <= 1'b0;
    end else begin
      if (state == BOOT) state <= RUN;
      inflight <= req;
      if (req) inflight_pc <= pc;
      if (redirect_valid) begin
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) fetch_misalign <= 1'b1;
      end else if (req) begin
        pc <= pc + XLEN'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .entry (push_entry),
    .pop   (handshake),
    .flush (redirect_valid),
    .head  (head),
    .empty (fifo_empty),
    .count (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (handshake)      perf_fetched   <= perf_fetched + 32'd1;
      if (redirect_valid) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`else
  assign perf_fetched   = '0;
  assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a PC-stream scoreboard checks every
// request and decode handshake, plus literal checks of latency and boundary cases.
module tb_instruction_fetch_unit;

  localparam logic [63:0] RESET_PC   = 64'h1000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_rd_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        fetch_misalign;
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;

  int n_cmp = 0;
  int n_fail = 0;

  // Scoreboard: next address to be requested, next PC decode must see, and
  // how many fetched instructions are held (buffered or in flight).
  logic [63:0] exp_req_pc = RESET_PC;
  logic [63:0] exp_hs_pc  = RESET_PC;
  int          outstanding = 0;
  int          n_req = 0;

  instruction_fetch_unit #(
    .XLEN       (64),
    .INSTR_W    (32),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_misalign (fetch_misalign),
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC3A5_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: data for a request seen in cycle t is presented in cycle t+1.
  initial begin
    logic        pend = 1'b0;
    logic [63:0] pend_addr = '0;
    forever begin
      @(negedge clk);
      imem_instr = pend ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      pend       = imem_rd_en;
      pend_addr  = imem_addr;
    end
  end

  // Per-cycle compare against the PC-stream model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_req_pc  = RESET_PC;
        exp_hs_pc   = RESET_PC;
        outstanding = 0;
      end else if (redirect_valid) begin
        check("mon_redirect_no_req", imem_rd_en, 1'b0);
        exp_req_pc  = {redirect_pc[63:2], 2'b00};
        exp_hs_pc   = {redirect_pc[63:2], 2'b00};
        outstanding = 0;
      end else begin
        if (imem_rd_en) begin
          check("mon_req_addr", imem_addr, exp_req_pc);
          exp_req_pc = exp_req_pc + 64'd4;
          outstanding++;
          n_req++;
        end
        if (id_valid && id_ready) begin
          check("mon_hs_pc", id_pc, exp_hs_pc);
          check("mon_hs_instr", id_instr, mem_word(exp_hs_pc));
          exp_hs_pc = exp_hs_pc + 64'd4;
          outstanding--;
        end
        check("mon_occupancy", (outstanding >= 0) && (outstanding <= FIFO_DEPTH), 1'b1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int hs;
    logic [31:0] exp_pf;
    logic [31:0] exp_pr;
`ifdef FETCH_PERF_EN
    exp_pf = 32'd5;
    exp_pr = 32'd2;
`else
    exp_pf = 32'd0;
    exp_pr = 32'd0;
`endif

    // Reset state
    repeat (2) cyc();
    check("rst_rd_en", imem_rd_en, 1'b0);
    check("rst_addr", imem_addr, 64'h0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 64'h0);
    check("rst_misalign", fetch_misalign, 1'b0);
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_redirects", perf_redirects, 32'h0);

    // Release: BOOT cycle, then back-to-back requests from RESET_PC
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_rd_en", imem_rd_en, 1'b0);
    check("boot_id_valid", id_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("c1_rd_en", imem_rd_en, 1'b1);
    check("c1_addr", imem_addr, 64'h1000);
    check("c1_id_valid", id_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("c2_addr", imem_addr, 64'h1004);
    check("c2_id_valid", id_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("c3_addr", imem_addr, 64'h1008);
    check("c3_id_valid", id_valid, 1'b1);
    check("c3_id_pc", id_pc, 64'h1000);
    check("c3_id_instr", id_instr, mem_word(64'h1000));
    cyc();

    // Steady stream: no bubbles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_id_valid", id_valid, 1'b1);
      cyc();
    end

    // Decode stall: FIFO fills, requests stop, PC holds
    id_ready = 1'b0;
    n0 = n_req;
    repeat (10) begin
      @(negedge clk);
      cyc();
    end
    check("stall_no_requests", n_req - n0, 0);
    check("stall_full", outstanding, FIFO_DEPTH);
    check("stall_rd_en", imem_rd_en, 1'b0);
    check("stall_id_valid", id_valid, 1'b1);
    check("stall_head_pc", id_pc, exp_hs_pc);
    id_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      cyc();
    end

    // Redirect with a buffered entry and a response in flight
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    @(negedge clk);
    check("ra_no_req", imem_rd_en, 1'b0);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("ra1_rd_en", imem_rd_en, 1'b1);
    check("ra1_addr", imem_addr, 64'h2000);
    check("ra1_id_valid", id_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("ra2_id_valid", id_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("ra3_id_valid", id_valid, 1'b1);
    check("ra3_id_pc", id_pc, 64'h2000);
    cyc();
    repeat (4) begin
      @(negedge clk);
      cyc();
    end

    // Full FIFO, then two back-to-back redirects; last (misaligned) wins
    id_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cyc();
    end
    check("full_before_redirect", outstanding, FIFO_DEPTH);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4000;
    @(negedge clk);
    check("rb0_misalign", fetch_misalign, 1'b0);
    cyc();
    redirect_pc = 64'h3002;
    @(negedge clk);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rb1_rd_en", imem_rd_en, 1'b1);
    check("rb1_addr", imem_addr, 64'h3000);
    check("rb1_misalign", fetch_misalign, 1'b1);
    check("rb1_id_valid", id_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("rb2_id_valid", id_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("rb3_id_valid", id_valid, 1'b1);
    check("rb3_id_pc", id_pc, 64'h3000);
    cyc();
    repeat (3) begin
      @(negedge clk);
      cyc();
    end

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("w1_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("w1_misalign_sticky", fetch_misalign, 1'b1);
    cyc();
    @(negedge clk);
    check("w2_addr", imem_addr, 64'h0);
    cyc();
    @(negedge clk);
    check("w3_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    @(negedge clk);
    check("w4_id_pc", id_pc, 64'h0);
    cyc();
    repeat (3) begin
      @(negedge clk);
      cyc();
    end

    // Reset mid-operation
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", imem_rd_en, 1'b0);
    check("mid_rst_addr", imem_addr, 64'h0);
    check("mid_rst_id_valid", id_valid, 1'b0);
    check("mid_rst_id_pc", id_pc, 64'h0);
    check("mid_rst_misalign", fetch_misalign, 1'b0);
    check("mid_rst_perf_fetched", perf_fetched, 32'h0);
    cyc();
    cyc();

    // Redirect in BOOT then in RUN, then exactly five handshakes
    id_ready       = 1'b0;
    rst_n          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    @(negedge clk);
    cyc();
    redirect_pc = 64'h200;
    @(negedge clk);
    check("p_redirect_no_req", imem_rd_en, 1'b0);
    cyc();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    hs = 0;
    for (int i = 0; i < 40 && hs < 5; i++) begin
      @(negedge clk);
      if (id_valid && id_ready) begin
        if (hs == 0) check("p_first_pc", id_pc, 64'h200);
        hs++;
      end
      cyc();
      id_ready = (hs < 5);
    end
    id_ready = 1'b0;
    check("p_handshakes_seen", hs, 5);
    repeat (3) begin
      @(negedge clk);
      cyc();
    end
    check("perf_fetched", perf_fetched, exp_pf);
    check("perf_redirects", perf_redirects, exp_pr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
